// File: rtl/acc_out_port.sv
// Output port FIFO between the accumulator and a slow external consumer.
// OUT instructions push the accumulator value; the consumer drains it over valid/ready.
module acc_out_port #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WIDTH-1:0]  acc_in,
  input  logic              en_out,
  output logic              stall,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              ovf_err_reg, ovf_err_next;
  logic              push, pop;

  // Status flags come straight from the registered occupancy, never from acc_in.
  assign stall     = (count_reg == FULL_CNT);
  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;
  assign count     = count_reg;
  assign ovf_err   = ovf_err_reg;

  assign push = en_out & ~stall;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    ovf_err_next = ovf_err_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
    // A rejected OUT while full is remembered until the next reset.
    if (en_out && stall) ovf_err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      ovf_err_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      ovf_err_reg <= ovf_err_next;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!clr && push) mem[wr_ptr_reg] <= acc_in;
  end

endmodule

// File: tb/tb_acc_out_port.sv
// Randomised and directed bench for acc_out_port against a queue-based model.
module tb_acc_out_port;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] acc_in = 8'h00;
  logic       en_out = 1'b0;
  logic       stall;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       ovf_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  acc_out_port #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .clr(clr), .acc_in(acc_in), .en_out(en_out), .stall(stall),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic tick(input logic c, input logic e, input logic [7:0] d, input logic r);
    bit full;
    bit popd;
    @(negedge clk);
    clr = c; en_out = e; acc_in = d; out_ready = r;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      full = (q.size() == 4);
      popd = (q.size() != 0) && r;
      if (e && full) m_ovf = 1'b1;
      if (popd) void'(q.pop_front());
      if (e && !full) q.push_back(d);
    end
    #1;
  endtask

  function automatic logic [7:0] exp_data();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  task automatic test_reset();
    tick(1'b1, 1'b1, 8'hFF, 1'b0);
    tick(1'b1, 1'b1, 8'hFF, 1'b0);
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", out_data); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf_err); end
    $display("[TB] reset done count=%0d valid=%b", count, out_valid);
  endtask

  task automatic test_ordering();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, vals[i], 1'b0);
      n_tests++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL order_fill_count got %0d exp %0d", count, i + 1); end
      n_tests++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL order_head got %h exp 11", out_data); end
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_data !== vals[i]) begin n_fail++; $display("FAIL order_drain got %h exp %h", out_data, vals[i]); end
      $display("[TB] order pop %0d data=%h", i, out_data);
      tick(1'b0, 1'b0, 8'h00, 1'b1);
    end
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_full();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
      n_tests++; if (stall !== (i >= 3)) begin n_fail++; $display("FAIL full_stall push %0d got %b exp %b", i, stall, i >= 3); end
      n_tests++; if (out_data !== 8'hA0) begin n_fail++; $display("FAIL full_hold got %h exp a0", out_data); end
    end
    n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %b exp 1", ovf_err); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (out_data !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL full_drain got %h exp %h", out_data, 8'hA0 + 8'(i)); end
      tick(1'b0, 1'b0, 8'h00, 1'b1);
    end
    n_tests++; if (count !== 3'd0 || out_data !== 8'h00) begin n_fail++; $display("FAIL full_dropped count=%0d data=%h exp 0/00", count, out_data); end
    $display("[TB] full scenario ovf=%b count=%0d", ovf_err, count);
  endtask

  task automatic test_full_pop();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
    n_tests++; if (stall !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL fpop_pre stall=%b count=%0d exp 1/4", stall, count); end
    tick(1'b0, 1'b1, 8'hB4, 1'b1);
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL fpop_count got %0d exp 3", count); end
    n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL fpop_ovf got %b exp 1", ovf_err); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fpop_stall got %b exp 0", stall); end
    n_tests++; if (out_data !== 8'hB1) begin n_fail++; $display("FAIL fpop_head got %h exp b1", out_data); end
    $display("[TB] full+pop count=%0d head=%h", count, out_data);
  endtask

  task automatic test_stream();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 8'(i), 1'b1);
      n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count cyc %0d got %0d exp 1", i, count); end
      n_tests++; if (out_data !== 8'(i)) begin n_fail++; $display("FAIL stream_data cyc %0d got %h exp %h", i, out_data, 8'(i)); end
      $display("[TB] stream cyc %0d data=%h", i, out_data);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b1, 8'hC1, 1'b0);
    tick(1'b0, 1'b1, 8'hC2, 1'b0);
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_pre got %0d exp 2", count); end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_clr count=%0d valid=%b exp 0/0", count, out_valid); end
    tick(1'b0, 1'b1, 8'h5A, 1'b0);
    n_tests++; if (out_data !== 8'h5A || count !== 3'd1) begin n_fail++; $display("FAIL mid_push data=%h count=%0d exp 5a/1", out_data, count); end
    $display("[TB] mid reset head=%h", out_data);
  endtask

  task automatic test_random();
    logic c, e, r;
    logic [7:0] d;
    int bad;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      d = 8'($urandom);
      tick(c, e, d, r);
      bad = 0;
      n_tests++;
      if (count !== 3'(q.size())) bad++;
      if (out_valid !== (q.size() != 0)) bad++;
      if (out_data !== exp_data()) bad++;
      if (stall !== (q.size() == 4)) bad++;
      if (ovf_err !== m_ovf) bad++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random cyc %0d got cnt=%0d v=%b d=%h st=%b ovf=%b exp cnt=%0d d=%h ovf=%b",
                 i, count, out_valid, out_data, stall, ovf_err, q.size(), exp_data(), m_ovf);
      end else begin
        $display("[TB] rand %0d clr=%b en=%b rdy=%b cnt=%0d d=%h", i, c, e, r, count, out_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_full();
    test_full_pop();
    test_stream();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
